irq_ctl: RTL and testbench
==========================

// Module: irq_ctl
// PURPOSE
//  Parametrised interrupt controller in front of the 65C02 core's single IRQ pin.
//  Synchronises NUM_IRQ external sources plus NMI, with per-channel edge/level mode and enable.
//  Priority-nests via in-service bits and supplies a per-channel vector low byte (page FF).
//  CPU uses vec_lo as ABL during the vector fetch; EOI is a core strobe.
// PARAMETERS
//  NUM_IRQ      8      number of maskable channels, 1..16; channel 0 highest priority
//  SYNC_STAGES  2      synchroniser depth on every input, >=2
//  VEC_BASE     8'hE0  vector of channel n = VEC_BASE + 2*n; elaboration error if VEC_BASE+2*NUM_IRQ > 8'hFA
//  NMI_VEC      8'hFA  NMI vector low byte
//  RST_VEC      8'hFC  reset vector low byte
//  BRK_VEC      8'hFE  spurious/BRK vector low byte
// PORTS
//  clk        in   1        CPU clock, all state on rising edge
//  RST        in   1        reset, asynchronous, active-high
//  irq_in     in   NUM_IRQ  raw interrupt sources, active-high
//  edge_mode  in   NUM_IRQ  1 = rising-edge latched, 0 = level (quasi-static)
//  irq_en     in   NUM_IRQ  per-channel enable mask
//  nmi_in     in   1        raw NMI, active-high, rising-edge
//  I          in   1        CPU I flag; masks irq_req only
//  ack        in   1        one-cycle strobe: CPU commits to an interrupt sequence
//  eoi        in   1        one-cycle strobe: end of interrupt for highest in-service channel
//  clr_we     in   1        software clear of edge pending bits
//  clr_mask   in   NUM_IRQ  bits to clear when clr_we=1
//  irq_req    out  1        maskable request to CPU
//  nmi_req    out  1        NMI request to CPU
//  vec_lo     out  8        vector low byte latched at ack
//  vec_chan   out  5        channel latched at ack; 5'h1F = NMI, 5'h1E = spurious
//  pending    out  NUM_IRQ  raw pending bits (before enable/priority)
//  in_service out  NUM_IRQ  in-service bits
// BEHAVIOUR
//  Reset (async): syncs, pending, nmi_pend, in_service, irq_req, nmi_req = 0.
//   vec_lo = RST_VEC, vec_chan = 5'h1E. All flops clear immediately on RST, mid-sequence included.
//  Sync: each input passes SYNC_STAGES flops to give s[n]; one extra flop gives s_d[n].
//   Edge = s & ~s_d.
//  Pending, edge mode: set on edge; cleared by ack selecting n or clr_we & clr_mask[n].
//   Set wins over any simultaneous clear.
//  Pending, level mode: pending[n] = s[n]; ack and clr ignored.
//   A mode change is effective next cycle.
//  Latency: irq_in high sampled at edge k -> pending visible after edge k+SYNC_STAGES.
//   irq_req is combinational from state, no added cycle.
//  cand = pending & irq_en & ~mask_hi.
//   mask_hi has a 1 at every index >= highest-priority in_service bit (nesting).
//   If in_service == 0, mask_hi = 0.
//  irq_req = |cand & ~I.
//  nmi_pend: set on NMI edge, cleared on ack when selected (set wins); nmi_req = nmi_pend.
//  FSM IDLE/SERVE (SERVE = in_service != 0 or nmi_active), ack taken in either state:
//   nmi_pend -> vec_lo=NMI_VEC, vec_chan=1F, clear nmi_pend, set nmi_active.
//   else |cand -> n = lowest set index; vec_lo=VEC_BASE+2n, vec_chan=n, set in_service[n].
//   else (BRK or I masked) -> vec_lo=BRK_VEC, vec_chan=1E; no other state change.
//   ack ignores I (CPU gates it).
//  vec_lo/vec_chan are registered at ack, valid from the next cycle, held until next ack.
//  eoi: if nmi_active, clear it; else clear lowest set in_service bit.
//   eoi with nothing in service: no-op.
//  ack+eoi same cycle: eoi applies to the state before the cycle, ack's set is applied after.
//  Vector arithmetic is 8-bit; no wrap is possible given the elaboration check.
// TESTING
//  RST mid-SERVE -> next cycle in_service=0, vec_lo=FC, irq_req=0 while RST is high.
//  Edge ch3, en all, I=0: pulse irq_in[3] 1 cycle -> pending[3] after 2 edges, irq_req=1;
//   ack -> vec_lo=E6, vec_chan=3, pending[3]=0, in_service=0x08.
//  Nesting: ch3 in service, ch5 pending -> irq_req=0; ch1 edge -> irq_req=1;
//   ack -> vec_lo=E2, in_service=0x0A; eoi -> 0x08.
//  NMI and ch0 pending same cycle, I=1: nmi_req=1, irq_req=0;
//   ack -> vec_lo=FA, vec_chan=1F; next ack -> E0.
//  Level ch2: hold high, ack -> vec E4; after eoi, pending[2] still 1;
//   drop input -> pending[2]=0 after 2 edges.
//  Edge ch4 arrives in same cycle as clr_we & clr_mask[4] -> pending[4]=1.
//   ack with no cand -> vec_lo=FE, vec_chan=1E.

Source files
------------

// File: rtl/irq_ctl_if.sv
// Signal bundle between the CPU/system side and the interrupt controller.
interface irq_ctl_if #(
    parameter int NUM_IRQ = 8
);
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] irq_en;
    logic               nmi_in;
    logic               I;
    logic               ack;
    logic               eoi;
    logic               clr_we;
    logic [NUM_IRQ-1:0] clr_mask;
    logic               irq_req;
    logic               nmi_req;
    logic [7:0]         vec_lo;
    logic [4:0]         vec_chan;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] in_service;

    modport master (
        output irq_in, edge_mode, irq_en, nmi_in, I, ack, eoi, clr_we, clr_mask,
        input  irq_req, nmi_req, vec_lo, vec_chan, pending, in_service
    );

    modport slave (
        input  irq_in, edge_mode, irq_en, nmi_in, I, ack, eoi, clr_we, clr_mask,
        output irq_req, nmi_req, vec_lo, vec_chan, pending, in_service
    );
endinterface

// File: rtl/irq_ctl.sv
// Nesting interrupt controller for a 65C02 core: synchronises sources, tracks
// pending/in-service state and latches the vector low byte on each ack.
module irq_ctl #(
    parameter int         NUM_IRQ     = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] VEC_BASE    = 8'hE0,
    parameter logic [7:0] NMI_VEC     = 8'hFA,
    parameter logic [7:0] RST_VEC     = 8'hFC,
    parameter logic [7:0] BRK_VEC     = 8'hFE
) (
    input logic      clk,
    input logic      RST,
    irq_ctl_if.slave bus
);
    localparam logic [4:0] CHAN_NMI  = 5'h1F;
    localparam logic [4:0] CHAN_SPUR = 5'h1E;

    if (NUM_IRQ < 1 || NUM_IRQ > 16) begin : g_bad_num_irq
        $error("irq_ctl: NUM_IRQ must be in 1..16");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("irq_ctl: SYNC_STAGES must be at least 2");
    end
    if (int'(VEC_BASE) + 2 * NUM_IRQ > 250) begin : g_bad_vec
        $error("irq_ctl: channel vectors overlap the NMI/reset/BRK vectors");
    end

    typedef enum logic {IDLE, SERVE} state_t;

    state_t                                state;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   irq_sync;
    logic [SYNC_STAGES-1:0]                nmi_sync;
    logic [NUM_IRQ-1:0]                    irq_s_d;
    logic                                  nmi_s_d;
    logic [NUM_IRQ-1:0]                    pending;
    logic [NUM_IRQ-1:0]                    in_service;
    logic                                  nmi_pend;
    logic                                  nmi_active;
    logic [7:0]                            vec_lo;
    logic [4:0]                            vec_chan;

    function automatic logic [4:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] chan_vec(input logic [4:0] n);
        return VEC_BASE + {2'b00, n, 1'b0};
    endfunction

    logic [NUM_IRQ-1:0] irq_s, irq_edge, is_low, mask_hi, cand, sel_onehot;
    logic [NUM_IRQ-1:0] ack_clr, sw_clr, pend_next, is_next;
    logic               nmi_s, nmi_edge, take_nmi, take_irq, eoi_go, act_next;
    logic [4:0]         sel;

    assign irq_s    = irq_sync[SYNC_STAGES-1];
    assign nmi_s    = nmi_sync[SYNC_STAGES-1];
    assign irq_edge = irq_s & ~irq_s_d;
    assign nmi_edge = nmi_s & ~nmi_s_d;

    // Lowest set in-service bit is the active level; it and everything below it is masked.
    assign is_low  = in_service & (~in_service + NUM_IRQ'(1));
    assign mask_hi = ~(is_low - NUM_IRQ'(1));
    assign cand    = pending & bus.irq_en & ~mask_hi;

    assign sel        = lowest_idx(cand);
    assign sel_onehot = cand & (~cand + NUM_IRQ'(1));
    assign take_nmi   = bus.ack & nmi_pend;
    assign take_irq   = bus.ack & ~nmi_pend & (|cand);
    assign ack_clr    = take_irq ? sel_onehot : '0;
    assign sw_clr     = bus.clr_we ? bus.clr_mask : '0;

    // Fresh edges win over ack/software clears; level channels just track the synchronised input.
    assign pend_next = (bus.edge_mode & (irq_edge | (pending & ~(ack_clr | sw_clr))))
                     | (~bus.edge_mode & irq_s);

    // eoi retires against the pre-cycle state, then an ack in the same cycle adds its bit.
    assign eoi_go   = bus.eoi && (state == SERVE);
    assign is_next  = ((eoi_go && !nmi_active) ? (in_service & ~is_low) : in_service) | ack_clr;
    assign act_next = (nmi_active & ~eoi_go) | take_nmi;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            irq_sync   <= '0;
            nmi_sync   <= '0;
            irq_s_d    <= '0;
            nmi_s_d    <= 1'b0;
            pending    <= '0;
            in_service <= '0;
            nmi_pend   <= 1'b0;
            nmi_active <= 1'b0;
            vec_lo     <= RST_VEC;
            vec_chan   <= CHAN_SPUR;
            state      <= IDLE;
        end else begin
            irq_sync   <= {irq_sync[SYNC_STAGES-2:0], bus.irq_in};
            nmi_sync   <= {nmi_sync[SYNC_STAGES-2:0], bus.nmi_in};
            irq_s_d    <= irq_s;
            nmi_s_d    <= nmi_s;
            pending    <= pend_next;
            in_service <= is_next;
            nmi_pend   <= nmi_edge | (nmi_pend & ~take_nmi);
            nmi_active <= act_next;
            if (take_nmi) begin
                vec_lo   <= NMI_VEC;
                vec_chan <= CHAN_NMI;
            end else if (take_irq) begin
                vec_lo   <= chan_vec(sel);
                vec_chan <= sel;
            end else if (bus.ack) begin
                vec_lo   <= BRK_VEC;
                vec_chan <= CHAN_SPUR;
            end
            state <= ((|is_next) || act_next) ? SERVE : IDLE;
        end
    end

    assign bus.irq_req    = (|cand) & ~bus.I;
    assign bus.nmi_req    = nmi_pend;
    assign bus.vec_lo     = vec_lo;
    assign bus.vec_chan   = vec_chan;
    assign bus.pending    = pending;
    assign bus.in_service = in_service;
endmodule

// File: tb/tb_irq_ctl.sv
// Bench for irq_ctl: directed vector table, reset/ack+eoi sequences, then
// random traffic checked against a channel-level behavioural model.
module tb_irq_ctl;
    localparam int SYNC = 2;

    logic clk;
    logic rst;

    irq_ctl_if #(.NUM_IRQ(8)) bus ();

    irq_ctl #(
        .NUM_IRQ(8), .SYNC_STAGES(SYNC), .VEC_BASE(8'hE0),
        .NMI_VEC(8'hFA), .RST_VEC(8'hFC), .BRK_VEC(8'hFE)
    ) dut (
        .clk(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit [8:0] hist[$];         // synchronised-input history, [0] = newest sample, bit 8 = NMI
    bit [7:0] m_pend, m_isv, m_vec;
    bit       m_npend, m_nact;
    bit [4:0] m_ch;

    function automatic int first_set(input bit [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i <= SYNC; i++) hist.push_back('0);
        m_pend = '0; m_isv = '0; m_npend = 0; m_nact = 0;
        m_vec = 8'hFC; m_ch = 5'h1E;
    endfunction

    function automatic bit [7:0] m_cand();
        bit [7:0] c;
        int hp;
        hp = first_set(m_isv);
        c = '0;
        for (int i = 0; i < 8; i++) c[i] = m_pend[i] & bus.irq_en[i] & (i < hp);
        return c;
    endfunction

    function automatic void model_step();
        bit [8:0] s, sd;
        bit [7:0] c, npend, nisv;
        bit       take_nmi, take_irq, nact;
        int       n;
        if (rst) begin
            model_reset();
            return;
        end
        s = hist[SYNC-1];
        sd = hist[SYNC];
        c = m_cand();
        n = first_set(c);
        take_nmi = bus.ack && m_npend;
        take_irq = bus.ack && !m_npend && (n < 8);
        nisv = m_isv;
        nact = m_nact;
        if (bus.eoi) begin
            if (m_nact) nact = 0;
            else if (first_set(m_isv) < 8) nisv[first_set(m_isv)] = 1'b0;
        end
        if (take_nmi) begin
            nact = 1; m_vec = 8'hFA; m_ch = 5'h1F;
        end else if (take_irq) begin
            nisv[n] = 1'b1; m_vec = 8'hE0 + 8'(2 * n); m_ch = 5'(n);
        end else if (bus.ack) begin
            m_vec = 8'hFE; m_ch = 5'h1E;
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.edge_mode[i])
                npend[i] = (s[i] & ~sd[i]) |
                           (m_pend[i] & !(take_irq && n == i) & !(bus.clr_we && bus.clr_mask[i]));
            else
                npend[i] = s[i];
        end
        m_npend = (s[8] & ~sd[8]) | (m_npend & !take_nmi);
        m_pend = npend;
        m_isv = nisv;
        m_nact = nact;
        hist.push_front({bus.nmi_in, bus.irq_in});
        void'(hist.pop_back());
    endfunction

    task automatic check_model(input string tag);
        bit [7:0] c;
        c = m_cand();
        check({tag, " pending"},    bus.pending,    m_pend);
        check({tag, " in_service"}, bus.in_service, m_isv);
        check({tag, " irq_req"},    bus.irq_req,    (|c) & ~bus.I);
        check({tag, " nmi_req"},    bus.nmi_req,    m_npend);
        check({tag, " vec_lo"},     bus.vec_lo,     m_vec);
        check({tag, " vec_chan"},   bus.vec_chan,   m_ch);
    endtask

    // Inputs change on the falling edge; the model advances on the rising edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input bit [7:0] irq, input bit [7:0] em, input bit [7:0] en, input bit nmi,
                          input bit i_flag, input bit ack, input bit eoi, input bit clr, input bit [7:0] clrm);
        bus.irq_in = irq; bus.edge_mode = em; bus.irq_en = en; bus.nmi_in = nmi; bus.I = i_flag;
        bus.ack = ack; bus.eoi = eoi; bus.clr_we = clr; bus.clr_mask = clrm;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit [7:0] irq, em, en;
        bit       nmi, i_flag, ack, eoi, clr;
        bit [7:0] clrm;
        bit [7:0] x_pend, x_isv;
        bit       x_irq, x_nmi;
        bit [7:0] x_vec;
        bit [4:0] x_ch;
    } vec_t;

    vec_t vt[$];

    initial begin
        // edge ch3 pulse, latency and ack
        vt.push_back('{8'h08, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFC, 5'h1E});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFC, 5'h1E});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 1, 0, 8'hFC, 5'h1E});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h08, 0, 0, 8'hE6, 5'h03});
        // nesting: ch5 blocked by ch3, ch1 preempts
        vt.push_back('{8'h20, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 0, 0, 8'hE6, 5'h03});
        vt.push_back('{8'h02, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h08, 0, 0, 8'hE6, 5'h03});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h20, 8'h08, 0, 0, 8'hE6, 5'h03});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h22, 8'h08, 1, 0, 8'hE6, 5'h03});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 8'h20, 8'h0A, 0, 0, 8'hE2, 5'h01});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h08, 0, 0, 8'hE2, 5'h01});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h00, 1, 0, 8'hE2, 5'h01});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h20, 0, 0, 8'hEA, 5'h05});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hEA, 5'h05});
        // NMI and ch0 together with I=1
        vt.push_back('{8'h01, 8'hFF, 8'hFF, 1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hEA, 5'h05});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hEA, 5'h05});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0, 1, 8'hEA, 5'h05});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'h00, 8'h01, 8'h00, 0, 0, 8'hFA, 5'h1F});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h01, 0, 0, 8'hE0, 5'h00});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 0, 0, 8'hE0, 5'h00});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE0, 5'h00});
        // level ch2
        vt.push_back('{8'h04, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE0, 5'h00});
        vt.push_back('{8'h04, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE0, 5'h00});
        vt.push_back('{8'h04, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h04, 8'h00, 1, 0, 8'hE0, 5'h00});
        vt.push_back('{8'h04, 8'hFB, 8'hFF, 0, 0, 1, 0, 0, 8'h00, 8'h04, 8'h04, 0, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h04, 8'hFB, 8'hFF, 0, 0, 0, 1, 0, 8'h00, 8'h04, 8'h00, 1, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h04, 8'h00, 1, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h04, 8'h00, 1, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFB, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE4, 5'h02});
        // edge ch4 against a simultaneous software clear, then spurious ack
        vt.push_back('{8'h10, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 1, 8'h10, 8'h10, 8'h00, 1, 0, 8'hE4, 5'h02});
        vt.push_back('{8'h00, 8'hFF, 8'hEF, 0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h00, 0, 0, 8'hFE, 5'h1E});
        vt.push_back('{8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 1, 8'h10, 8'h00, 8'h00, 0, 0, 8'hFE, 5'h1E});

        // ---------------- reset state ----------------
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        model_reset();
        repeat (2) cycle();
        check("reset pending",    bus.pending,    8'h00);
        check("reset in_service", bus.in_service, 8'h00);
        check("reset irq_req",    bus.irq_req,    1'b0);
        check("reset nmi_req",    bus.nmi_req,    1'b0);
        check("reset vec_lo",     bus.vec_lo,     8'hFC);
        check("reset vec_chan",   bus.vec_chan,   5'h1E);
        rst = 1'b0;

        foreach (vt[k]) begin
            set_in(vt[k].irq, vt[k].em, vt[k].en, vt[k].nmi, vt[k].i_flag,
                   vt[k].ack, vt[k].eoi, vt[k].clr, vt[k].clrm);
            cycle();
            check($sformatf("tbl%0d pending", k),    bus.pending,    vt[k].x_pend);
            check($sformatf("tbl%0d in_service", k), bus.in_service, vt[k].x_isv);
            check($sformatf("tbl%0d irq_req", k),    bus.irq_req,    vt[k].x_irq);
            check($sformatf("tbl%0d nmi_req", k),    bus.nmi_req,    vt[k].x_nmi);
            check($sformatf("tbl%0d vec_lo", k),     bus.vec_lo,     vt[k].x_vec);
            check($sformatf("tbl%0d vec_chan", k),   bus.vec_chan,   vt[k].x_ch);
        end

        // ---------------- reset in the middle of servicing ----------------
        set_in(8'h08, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        set_in(8'h20, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 8'h00); cycle();
        check("serve in_service", bus.in_service, 8'h08);
        set_in(8'h01, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b1;
        model_reset();
        #1;
        check("async rst in_service", bus.in_service, 8'h00);
        check("async rst vec_lo",     bus.vec_lo,     8'hFC);
        check("async rst irq_req",    bus.irq_req,    1'b0);
        cycle();
        check("rst held in_service", bus.in_service, 8'h00);
        check("rst held vec_lo",     bus.vec_lo,     8'hFC);
        check("rst held irq_req",    bus.irq_req,    1'b0);
        check("rst held pending",    bus.pending,    8'h00);
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00);
        rst = 1'b0;

        // ---------------- ack and eoi in the same cycle ----------------
        set_in(8'h08, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        cycle();
        set_in(8'h02, 8'hFF, 8'hFF, 0, 0, 1, 0, 0, 8'h00); cycle();
        check_model("ackeoi setup");
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00); cycle();
        cycle();
        check("ackeoi pre pending", bus.pending, 8'h02);
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 1, 1, 0, 8'h00); cycle();
        check("ackeoi in_service", bus.in_service, 8'h02);
        check("ackeoi vec_lo",     bus.vec_lo,     8'hE2);
        check_model("ackeoi");
        set_in(8'h00, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 8'h00); cycle();
        check("ackeoi retire", bus.in_service, 8'h00);

        // ---------------- random traffic against the model ----------------
        for (int t = 0; t < 800; t++) begin
            bit [7:0] irq, em, en, clrm;
            irq = bus.irq_in;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            em = bus.edge_mode;
            if ($urandom_range(0, 40) == 0) em = 8'($urandom);
            en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            clrm = 8'($urandom);
            set_in(irq, em, en, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0, clrm);
            cycle();
            check_model($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
